instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the RV32I control unit and datapath.
- Owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small in-order prefetch FIFO and presents the head instruction with its PC and the pre-split decode fields (OP, funct3, funct7).
- Redirects and flushes on a taken branch (PCSrc) reported for the instruction being consumed.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC owner, imem req/gnt/rvalid master, prefetch FIFO.
// Redirects on a taken branch and discards in-flight old-path responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  OP,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        misalign
);

    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] CAP  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          misalign_q;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];

    logic          grant, resp, head_valid;
    logic          consume, redirect, push, pop;
    logic [CW:0]   used;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Issue cap counts FIFO entries plus in-flight reads, so no overflow
    assign used       = {1'b0, cnt_q} + {1'b0, out_q};
    assign imem_req   = (state_q != S_BOOT) && (used < CAP);
    assign imem_addr  = fetch_pc_q;
    assign grant      = imem_req && imem_gnt;
    assign resp       = imem_rvalid && (out_q != '0);
    assign head_valid = (cnt_q != '0);
    assign consume    = head_valid && !stall;
    assign redirect   = consume && PCSrc;
    assign push       = resp && (disc_q == '0) && !redirect;
    assign pop        = consume && !redirect;

    always_comb begin
        out_d      = out_q + CW'(grant) - CW'(resp);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect) begin
            // Everything still in flight after this cycle is old-path
            fetch_pc_d = {branch_target[31:2], 2'b00};
            resp_pc_d  = {branch_target[31:2], 2'b00};
            disc_d     = out_d;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
        end else begin
            if (resp && (disc_q != '0)) begin
                disc_d = disc_q - 1'b1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_d      = inc_ptr(wr_q);
            end
            if (pop) begin
                rd_d = inc_ptr(rd_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT:  state_q <= S_RUN;
                default: state_q <= (disc_d != '0) ? S_DRAIN : S_RUN;
            endcase
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            misalign_q <= redirect && (branch_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= imem_rdata;
            pc_q[wr_q]   <= resp_pc_q;
        end
    end

    assign instr_valid = head_valid;
    assign instr       = head_valid ? data_q[rd_q] : NOP;
    assign instr_pc    = head_valid ? pc_q[rd_q] : '0;
    assign OP          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order memory model
// and an architectural PC-sequence reference.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  OP;
    logic [2:0]  funct3;
    logic        funct7;
    logic        misalign;

    instr_fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .branch_target(branch_target),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .OP           (OP),
        .funct3       (funct3),
        .funct7       (funct7),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          consumed = 0;
    int          gnt_pct, stall_pct, br_pct, min_lat, max_lat, stray_pct;
    bit          br7 = 0;
    bit          force_en = 0;
    logic [31:0] force_pc, force_bt;
    logic [31:0] exp_pc = RST_PC;
    logic        exp_mis = 1'b0;
    bit          hold_chk = 0;
    logic [31:0] hold_addr = '0;
    bit          redir_prev = 0;
    logic [31:0] redir_tgt = '0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'h0000_1000 + 32'($urandom_range(255)) * 32'd4;
        if ($urandom_range(19) == 0)
            t = 32'hFFFF_FFF0 | (32'($urandom_range(3)) * 32'd4);
        if ($urandom_range(9) == 0)
            t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        logic        rv, g, s, p, from_q, cons;
        logic [31:0] rd, bt, w;
        rsp_t        r;
        int          due;
        chk("misalign", 32'(misalign), 32'(exp_mis));
        chk("addr_align", 32'(imem_addr[1:0]), 0);
        chk("cap", 32'(q.size() <= DEPTH), 1);
        if (hold_chk) begin
            chk("req_hold", 32'(imem_req), 1);
            chk("addr_hold", imem_addr, hold_addr);
        end
        if (redir_prev) begin
            chk("redir_addr", imem_addr, redir_tgt);
            chk("flush", 32'(instr_valid), 0);
        end
        if (instr_valid) begin
            w = word_at(exp_pc);
            chk("pc", instr_pc, exp_pc);
            chk("instr", instr, w);
            chk("op", 32'(OP), 32'(w[6:0]));
            chk("funct3", 32'(funct3), 32'(w[14:12]));
            chk("funct7", 32'(funct7), 32'(w[30]));
        end else begin
            chk("nop", instr, NOP);
        end
        from_q = 0;
        rv = 0;
        rd = '0;
        if (q.size() > 0) begin
            if (q[0].due <= cyc) begin
                rv = 1;
                from_q = 1;
                rd = word_at(q[0].addr);
            end
        end else if (int'($urandom_range(99)) < stray_pct) begin
            rv = 1;
            rd = $urandom;
        end
        g = int'($urandom_range(99)) < gnt_pct;
        s = int'($urandom_range(99)) < stall_pct;
        p = (int'($urandom_range(99)) < br_pct) ||
            (br7 && (consumed % 7 == 6));
        bt = rand_target();
        if (force_en && instr_valid && instr_pc == force_pc) begin
            s = 0;
            p = 1;
            bt = force_bt;
            force_en = 0;
        end
        cons = instr_valid && !s;
        imem_gnt = g;
        imem_rvalid = rv;
        imem_rdata = rd;
        stall = s;
        PCSrc = p;
        branch_target = bt;
        hold_chk = imem_req && !g && !(cons && p);
        hold_addr = imem_addr;
        redir_prev = cons && p;
        redir_tgt = {bt[31:2], 2'b00};
        exp_mis = cons && p && (bt[1:0] != 2'b00);
        if (cons) begin
            consumed++;
            exp_pc = p ? {bt[31:2], 2'b00} : exp_pc + 32'd4;
        end
        if (from_q) void'(q.pop_front());
        if (imem_req && g) begin
            due = cyc + int'($urandom_range(max_lat, min_lat));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = imem_addr;
            r.due = due;
            q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        imem_gnt = 0;
        imem_rvalid = 0;
        stall = 0;
        PCSrc = 0;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 0);
        chk("rst_misalign", 32'(misalign), 0);
        q.delete();
        exp_pc = RST_PC;
        exp_mis = 0;
        hold_chk = 0;
        redir_prev = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 0);
        @(posedge clk);
        #1;
        cyc++;
        last_due = cyc;
    endtask

    task automatic set_cfg(input int g, input int lo, input int hi,
                           input int s, input int b, input bit b7,
                           input int st);
        gnt_pct = g;
        min_lat = lo;
        max_lat = hi;
        stall_pct = s;
        br_pct = b;
        br7 = b7;
        stray_pct = st;
    endtask

    task automatic run_phase(input string tag, input int n);
        int start;
        start = consumed;
        for (int i = 0; i < n; i++) step();
        chk(tag, 32'(consumed > start + n / 20), 1);
    endtask

    initial begin
        set_cfg(100, 1, 1, 0, 0, 0, 0);
        apply_reset();

        force_en = 1;
        force_pc = 32'h0000_0010;
        force_bt = 32'h0000_0100;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) chk("first_req", 32'(imem_req), 1);
            if (i < 6) chk("seq_valid", 32'(instr_valid), 32'(i >= 2));
            step();
        end

        force_en = 1;
        force_pc = 32'h0000_0108;
        force_bt = 32'h0000_0202;
        for (int i = 0; i < 14; i++) step();
        force_en = 0;

        set_cfg(100, 1, 1, 100, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        chk("stall_req_drop", 32'(imem_req), 0);
        chk("stall_q_empty", 32'(q.size()), 0);
        set_cfg(100, 1, 1, 0, 0, 0, 0);
        run_phase("progress_unstall", 10);

        set_cfg(70, 1, 5, 20, 5, 1, 5);
        run_phase("progress_a", 1500);
        set_cfg(100, 1, 1, 0, 0, 1, 0);
        run_phase("progress_b", 500);
        set_cfg(40, 3, 5, 40, 15, 1, 5);
        run_phase("progress_c", 1500);

        set_cfg(100, 5, 5, 0, 0, 0, 0);
        for (int i = 0; i < 50 && q.size() < 3; i++) step();
        chk("inflight3", 32'(q.size() >= 3), 1);
        apply_reset();
        set_cfg(100, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) chk("restart_addr", imem_addr, RST_PC);
            step();
        end
        run_phase("progress_restart", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
